// File: rtl/or_result_fifo.sv
// or_result_fifo: accepts operand pairs and queues their bitwise OR in a DEPTH-entry FIFO.
module or_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              accept_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic push, pop;
    always_comb begin
        in_ready = level != FULL;
        out_valid = level != '0;
        push = in_valid && in_ready;
        pop = out_valid && out_ready;
        out_data = mem[rptr];
        out_zero = out_valid && out_data == '0;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            accept_cnt <= '0;
        end else begin
            wptr <= push ? wptr + 1'b1 : wptr;
            rptr <= pop ? rptr + 1'b1 : rptr;
            level <= push && !pop ? level + 1'b1 : pop && !push ? level - 1'b1 : level;
            accept_cnt <= push && accept_cnt != 16'hFFFF ? accept_cnt + 1'b1 : accept_cnt;
        end
    // Storage is deliberately not reset; stale entries are unreachable once level is cleared.
    always_ff @(posedge clk)
        if (push) mem[wptr] <= a | b;
endmodule

// File: doc/or_result_fifo.md
OR_RESULT_FIFO -- requirements
Module: or_result_fifo

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of result entries (power of 2, >=2).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 in_valid  input  1  producer presents an operand pair.
REQ-006 in_ready  output  1  block can accept an operand pair this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer accepts head entry this cycle.
REQ-011 out_data  output  WIDTH  head entry (stored a|b).
REQ-012 out_zero  output  1  head entry is all-zero, qualified by out_valid.
REQ-013 level  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-014 accept_cnt  output  16  saturating count of accepted operand pairs.

Function
REQ-015 The block SHALL accept an input (push) on a rising edge where in_valid=1 and in_ready=1.
REQ-016 On push the block SHALL store the bitwise OR of a and b sampled at that edge into the entry at the write pointer.
REQ-017 The block SHALL pop the head entry on a rising edge where out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL equal (level != DEPTH), derived from registered state only, independent of out_ready.
REQ-019 out_valid SHALL equal (level != 0), derived from registered state only.
REQ-020 out_data SHALL present the entry at the read pointer; value is don't-care when out_valid=0.
REQ-021 out_zero SHALL be 1 only when out_valid=1 and out_data is all zeros, else 0.
REQ-022 Latency: an entry pushed at edge N SHALL be visible on out_valid/out_data from edge N onward (first pop possible at edge N+1); no combinational in-to-out bypass.
REQ-023 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-024 Push only: level +1; pop only: level -1; push and pop on the same edge: level unchanged, both pointers advance.
REQ-025 When full (level=DEPTH), in_ready=0 and in_valid SHALL be ignored, even if a pop occurs on the same edge.
REQ-026 When empty, out_ready SHALL be ignored and no pointer SHALL move on the read side.
REQ-027 Entries SHALL be delivered in push order with no loss or duplication.
REQ-028 accept_cnt SHALL increment by 1 on each push and hold at 16'hFFFF once reached.
REQ-029 The producer SHALL hold a, b, in_valid stable until accepted; the block does not check this.

Reset
REQ-030 While rst=0, level, both pointers and accept_cnt SHALL be 0 asynchronously.
REQ-031 During and after reset, outputs SHALL be in_ready=1, out_valid=0, out_zero=0, level=0, accept_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-033 The first push SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 Single: a=8'h0F, b=8'hF0 push, out_ready=0 -> next cycle out_valid=1, out_data=8'hFF, level=1, accept_cnt=1.
REQ-035 Fill: push 4 pairs (01|02, 04|08, 00|00, 80|00) with out_ready=0 -> level=4, in_ready=0; 5th in_valid ignored; drain gives 03,0C,00,80 with out_zero=1 only on third.
REQ-036 Full + simultaneous: level=4, in_valid=1, out_ready=1 -> pop occurs, no push, level=3, in_ready=1 next cycle.
REQ-037 Streaming: in_valid=1, out_ready=1 continuously for 20 cycles with incrementing a, b=0 -> level stays 1 after first cycle, outputs in order, pointers wrap cleanly.
REQ-038 Reset mid-run: level=3, drive rst=0 between edges -> immediately level=0, out_valid=0, in_ready=1, accept_cnt=0; after release, first push yields correct data.
REQ-039 Saturation: force 65 537 pushes with out_ready=1 -> accept_cnt holds at 16'hFFFF, data path unaffected.
